// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding and width constants.
package cpu_pkg;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_STALL = 2'd1,
      S_DRAIN = 2'd2
   } fetch_state_t;

   localparam int WORD_STEP   = 2;
   localparam int INSTR_W     = 16;
   localparam int OPCODE_W    = 4;
   localparam int PC_OFF_W    = 10;
   localparam int FETCH_DEPTH = 2;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, instruction} pairs; the head is read straight from
// the storage registers so consumers see a registered output.
module fetch_buffer
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_flush,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [ADDR_W-1:0]  i_push_pc,
   input  logic [INSTR_W-1:0] i_push_instr,
   output logic [ADDR_W-1:0]  o_head_pc,
   output logic [INSTR_W-1:0] o_head_instr,
   output logic               o_full,
   output logic               o_empty
);

   logic [ADDR_W-1:0]  r_pc    [FETCH_DEPTH];
   logic [INSTR_W-1:0] r_instr [FETCH_DEPTH];
   logic               r_wr_ptr;
   logic               r_rd_ptr;
   logic [1:0]         r_count;
   logic               w_push_ok;
   logic               w_pop_ok;

   assign w_pop_ok  = i_pop && (r_count != 2'd0);
   // A push into a full buffer is only legal when the head leaves at the same edge.
   assign w_push_ok = i_push && ((r_count != 2'd2) || w_pop_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FETCH_DEPTH; i++) begin
            r_pc[i]    <= RESET_PC;
            r_instr[i] <= '0;
         end
      end else if (w_push_ok && !i_flush) begin
         r_pc[r_wr_ptr]    <= i_push_pc;
         r_instr[r_wr_ptr] <= i_push_instr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop_ok)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_pc    = r_pc[r_rd_ptr];
   assign o_head_instr = r_instr[r_rd_ptr];
   assign o_full       = (r_count == 2'd2);
   assign o_empty      = (r_count == 2'd0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads, buffers two
// fetched words and redirects on jump requests relative to the last accepted pc.
module inst_fetch_unit
   import cpu_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic                clk,
   input  logic                rst,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_rd,
   input  logic [INSTR_W-1:0]  mem_rdata,
   input  logic                mem_ready,
   output logic [INSTR_W-1:0]  instruction,
   output logic [ADDR_W-1:0]   inst_pc,
   output logic                inst_valid,
   input  logic                inst_ready,
   input  logic                branch_en,
   input  logic [PC_OFF_W-1:0] pc_offset,
   output logic [1:0]          fetch_state
);

   fetch_state_t       r_state;
   fetch_state_t       w_state_next;
   logic [ADDR_W-1:0]  r_fetch_pc;
   logic [ADDR_W-1:0]  r_last_pc;
   logic [ADDR_W-1:0]  r_drain_addr;
   logic [ADDR_W-1:0]  w_off_ext;
   logic [ADDR_W-1:0]  w_target;
   logic [ADDR_W-1:0]  w_head_pc;
   logic [INSTR_W-1:0] w_head_instr;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               w_inst_valid;

   assign w_off_ext    = {{(ADDR_W-PC_OFF_W){pc_offset[PC_OFF_W-1]}}, pc_offset};
   assign w_target     = r_last_pc + ADDR_W'(WORD_STEP) + (w_off_ext << 1);
   assign w_inst_valid = !w_empty && !branch_en;
   assign w_pop        = w_inst_valid && inst_ready;
   // Data returning in a branch cycle belongs to the abandoned stream.
   assign w_push       = (r_state == S_REQ) && mem_ready && !branch_en;

   fetch_buffer #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC)
   ) u_fetch_buffer (
      .clk          (clk),
      .rst          (rst),
      .i_flush      (branch_en),
      .i_push       (w_push),
      .i_pop        (w_pop),
      .i_push_pc    (r_fetch_pc),
      .i_push_instr (mem_rdata),
      .o_head_pc    (w_head_pc),
      .o_head_instr (w_head_instr),
      .o_full       (w_full),
      .o_empty      (w_empty)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_REQ: begin
            if (branch_en)
               w_state_next = mem_ready ? S_REQ : S_DRAIN;
            else if (w_push && !w_pop && !w_empty)
               w_state_next = S_STALL;
         end
         S_STALL: begin
            if (branch_en || w_pop)
               w_state_next = S_REQ;
         end
         S_DRAIN: begin
            if (mem_ready)
               w_state_next = S_REQ;
         end
         default: w_state_next = S_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_REQ;
         r_fetch_pc   <= RESET_PC;
         r_last_pc    <= RESET_PC - ADDR_W'(WORD_STEP);
         r_drain_addr <= RESET_PC;
      end else begin
         r_state <= w_state_next;
         if (branch_en)
            r_fetch_pc <= w_target;
         else if (w_push)
            r_fetch_pc <= r_fetch_pc + ADDR_W'(WORD_STEP);
         if (w_pop)
            r_last_pc <= w_head_pc;
         if (branch_en && (r_state == S_REQ))
            r_drain_addr <= r_fetch_pc;
      end
   end

   // The read strobe is gated by reset so an in-flight read is abandoned at once.
   assign mem_rd      = !rst && (r_state != S_STALL);
   assign mem_addr    = (r_state == S_DRAIN) ? r_drain_addr : r_fetch_pc;
   assign instruction = w_head_instr;
   assign inst_pc     = w_head_pc;
   assign inst_valid  = w_inst_valid;
   assign fetch_state = r_state;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: directed scenarios queue expected
// {pc, instr} pairs, a negedge monitor checks every accepted instruction.
module tb_inst_fetch_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [15:0] mem_rdata;
   logic        mem_ready;
   logic [15:0] instruction;
   logic [15:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        branch_en = 1'b0;
   logic [9:0]  pc_offset = 10'h000;
   logic [1:0]  fetch_state;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks = 0;
   int          errors = 0;
   int          pop_cnt = 0;
   int          mem_lat = 0;
   int          wait_cnt;
   int          cyc;
   logic        hold_q = 1'b0;
   logic [15:0] hold_pc;
   logic [15:0] hold_instr;

   always #5 clk = ~clk;

   inst_fetch_unit #(
      .ADDR_W   (16),
      .RESET_PC (16'h0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_addr    (mem_addr),
      .mem_rd      (mem_rd),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .instruction (instruction),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .branch_en   (branch_en),
      .pc_offset   (pc_offset),
      .fetch_state (fetch_state)
   );

   // Memory: word at address A reads as 16'h4000 + A, ready after mem_lat wait cycles.
   always @(posedge clk or posedge rst) begin
      if (rst)
         wait_cnt <= 0;
      else if (mem_rd && !mem_ready)
         wait_cnt <= wait_cnt + 1;
      else
         wait_cnt <= 0;
   end
   assign mem_ready = mem_rd && (wait_cnt >= mem_lat);
   assign mem_rdata = 16'h4000 + mem_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic void expect_word(input logic [15:0] pc);
      exp_t t;
      t.pc    = pc;
      t.instr = 16'h4000 + pc;
      exp_q.push_back(t);
   endfunction

   // Monitor: every accepted instruction is checked against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         hold_q = 1'b0;
      end else begin
         if (hold_q && inst_valid) begin
            chk("hold_pc", inst_pc, hold_pc);
            chk("hold_instr", instruction, hold_instr);
         end
         if (inst_valid && inst_ready) begin
            $display("pop pc=%h instr=%h", inst_pc, instruction);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pop: got pc %h instr %h, expected none", inst_pc, instruction);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pop_pc", inst_pc, mon_e.pc);
               chk("pop_instr", instruction, mon_e.instr);
            end
            pop_cnt++;
         end
         hold_q     = inst_valid && !inst_ready;
         hold_pc    = inst_pc;
         hold_instr = instruction;
      end
   end

   // Called at posedge+1; returns with inst_ready low after exactly n accepts.
   task automatic run_pops(input int n, output int ncyc);
      int tgt;
      tgt  = pop_cnt + n;
      ncyc = 0;
      inst_ready = 1'b1;
      while (pop_cnt < tgt && ncyc < 100) begin
         @(posedge clk);
         #1;
         ncyc++;
      end
      inst_ready = 1'b0;
      chk("pop_count", pop_cnt, tgt);
   endtask

   task automatic wait_state(input logic [1:0] st, input string name);
      int k;
      k = 0;
      while (fetch_state != st && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(name, fetch_state, st);
   endtask

   task automatic do_branch(input logic [9:0] off);
      branch_en = 1'b1;
      pc_offset = off;
      @(negedge clk);
      chk("valid_in_branch", inst_valid, 1'b0);
      @(posedge clk);
      #1;
      branch_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      $display("reset check %s", tag);
      chk("rst_mem_rd", mem_rd, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_instruction", instruction, 16'h0000);
      chk("rst_inst_pc", inst_pc, 16'h0000);
      chk("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_fetch_state", fetch_state, S_REQ);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("initial");

      // Reset release with the consumer stalled: two words buffered, then stall.
      rst = 1'b0;
      @(negedge clk);
      chk("first_mem_rd", mem_rd, 1'b1);
      chk("first_mem_addr", mem_addr, 16'h0000);
      repeat (5) @(posedge clk);
      #1;
      chk("stall_state", fetch_state, S_STALL);
      chk("stall_mem_rd", mem_rd, 1'b0);
      chk("stall_valid", inst_valid, 1'b1);
      chk("stall_head_pc", inst_pc, 16'h0000);
      chk("stall_head_instr", instruction, 16'h4000);

      // Release: pcs 0..0x10 delivered one per cycle.
      for (int i = 0; i < 9; i++) expect_word(16'(2 * i));
      run_pops(9, cyc);
      chk("throughput_cycles", cyc, 9);

      // Backward jump after accepting 0x0010: target 0x000E.
      wait_state(S_STALL, "pre_branch1_stall");
      do_branch(10'h3FE);
      chk("branch1_mem_rd", mem_rd, 1'b1);
      chk("branch1_mem_addr", mem_addr, 16'h000E);
      for (int i = 0; i < 4; i++) expect_word(16'h000E + 16'(2 * i));
      run_pops(4, cyc);
      wait_state(S_STALL, "pre_drain_stall");

      // Slow memory: jump while a read is outstanding forces a drain.
      mem_lat = 3;
      expect_word(16'h0016);
      run_pops(1, cyc);
      chk("drain_rd_rise", mem_rd, 1'b1);
      chk("drain_rd_addr", mem_addr, 16'h001A);
      do_branch(10'h010);
      chk("drain_state", fetch_state, S_DRAIN);
      chk("drain_mem_addr", mem_addr, 16'h001A);
      chk("drain_mem_rd", mem_rd, 1'b1);
      wait_state(S_REQ, "drain_exit");
      chk("drain_target_addr", mem_addr, 16'h0038);
      expect_word(16'h0038);
      expect_word(16'h003A);
      run_pops(2, cyc);
      mem_lat = 0;
      wait_state(S_STALL, "pre_wrap_stall");

      // Jump to 0xFFFE and fetch across the address wrap.
      do_branch(10'h3E1);
      chk("wrap_mem_addr", mem_addr, 16'hFFFE);
      expect_word(16'hFFFE);
      expect_word(16'h0000);
      expect_word(16'h0002);
      run_pops(3, cyc);
      wait_state(S_STALL, "pre_ff00_stall");
      do_branch(10'h37E);
      chk("ff00_mem_addr", mem_addr, 16'hFF00);
      expect_word(16'hFF00);
      run_pops(1, cyc);
      wait_state(S_STALL, "pre_1ff_stall");
      do_branch(10'h1FF);
      chk("wrap_target_addr", mem_addr, 16'h0300);
      expect_word(16'h0300);
      expect_word(16'h0302);
      run_pops(2, cyc);
      wait_state(S_STALL, "pre_reset_stall");

      // Asynchronous reset with the buffer full, then again mid-read.
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("buffer_full");
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_lat = 3;
      @(negedge clk);
      chk("midread_mem_rd", mem_rd, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("midread_rst_mem_rd", mem_rd, 1'b0);
      chk("midread_rst_state", fetch_state, S_REQ);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mem_lat = 0;
      expect_word(16'h0000);
      expect_word(16'h0002);
      run_pops(2, cyc);

      repeat (2) @(posedge clk);
      #1;
      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
